dmem_arbiter: RTL and testbench

Two-master arbiter for the single-ported data memory. It shares the data-memory port between the processor's load/store path (master 0) and a secondary bus master (master 1, e.g. a DMA or debug loader). It grants one master per cycle with a registered ownership state machine, round-robin fairness and a hold cap. Read data returns one cycle after the granted access. It sits between the masters and the data memory / memory-mapped I/O decode.

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between two masters using round-robin with a hold cap.
// Define DMEM_ARB_FIXED_PRIO_EN to give master 0 fixed priority. That build has no rr_ptr or hold_cnt.
module dmem_arbiter #(
    parameter int DBITS     = 32,
    parameter int ADDR_BITS = 11,
    parameter int MAX_HOLD  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_m0_req,
    input  logic                 i_m0_we,
    input  logic [ADDR_BITS-1:0] i_m0_addr,
    input  logic [DBITS-1:0]     i_m0_wdata,
    input  logic                 i_m1_req,
    input  logic                 i_m1_we,
    input  logic [ADDR_BITS-1:0] i_m1_addr,
    input  logic [DBITS-1:0]     i_m1_wdata,
    output logic                 o_m0_gnt,
    output logic                 o_m1_gnt,
    output logic                 o_m0_rvalid,
    output logic                 o_m1_rvalid,
    output logic [DBITS-1:0]     o_m0_rdata,
    output logic [DBITS-1:0]     o_m1_rdata,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [DBITS-1:0]     o_mem_wdata,
    output logic                 o_mem_we,
    input  logic [DBITS-1:0]     i_mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

    state_t             r_state;
    logic               r_m0_rvalid;
    logic               r_m1_rvalid;
    logic [DBITS-1:0]   r_m0_rdata;
    logic [DBITS-1:0]   r_m1_rdata;
    logic               w_gnt0;
    logic               w_gnt1;

    // Grants follow the request combinationally so an owning master is served in the cycle it asks.
    assign w_gnt0 = (r_state == ST_OWN0) && i_m0_req;
    assign w_gnt1 = (r_state == ST_OWN1) && i_m1_req;

    assign o_m0_gnt    = w_gnt0;
    assign o_m1_gnt    = w_gnt1;
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;

    always_comb begin
        o_mem_addr  = i_m0_addr;
        o_mem_wdata = i_m0_wdata;
        o_mem_we    = 1'b0;
        case (r_state)
            ST_OWN0: o_mem_we = i_m0_we && w_gnt0;
            ST_OWN1: begin
                o_mem_addr  = i_m1_addr;
                o_mem_wdata = i_m1_wdata;
                o_mem_we    = i_m1_we && w_gnt1;
            end
            default: o_mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_gnt0 && !i_m0_we;
            r_m1_rvalid <= w_gnt1 && !i_m1_we;
            if (w_gnt0 && !i_m0_we) r_m0_rdata <= i_mem_rdata;
            if (w_gnt1 && !i_m1_we) r_m1_rdata <= i_mem_rdata;
        end
    end

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Master 0 preempts master 1 at the next cycle boundary.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_m0_req)      r_state <= ST_OWN0;
                    else if (i_m1_req) r_state <= ST_OWN1;
                end
                ST_OWN0: begin
                    if (!i_m0_req) r_state <= i_m1_req ? ST_OWN1 : ST_IDLE;
                end
                ST_OWN1: begin
                    if (i_m0_req)       r_state <= ST_OWN0;
                    else if (!i_m1_req) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    localparam int             HCW       = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);

    logic           r_rr_ptr;
    logic [HCW-1:0] r_hold_cnt;
    logic           w_cap0;
    logic           w_cap1;

    // At the cap the waiting master takes over on the very next cycle, with no idle cycle between owners.
    assign w_cap0 = w_gnt0 && (r_hold_cnt >= HOLD_LAST) && i_m1_req;
    assign w_cap1 = w_gnt1 && (r_hold_cnt >= HOLD_LAST) && i_m0_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hold_cnt <= '0;
                    if (i_m0_req && i_m1_req) r_state <= r_rr_ptr ? ST_OWN1 : ST_OWN0;
                    else if (i_m0_req)        r_state <= ST_OWN0;
                    else if (i_m1_req)        r_state <= ST_OWN1;
                end
                ST_OWN0: begin
                    if (!i_m0_req || w_cap0) begin
                        r_state    <= i_m1_req ? ST_OWN1 : ST_IDLE;
                        r_rr_ptr   <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt < HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (!i_m1_req || w_cap1) begin
                        r_state    <= i_m0_req ? ST_OWN0 : ST_IDLE;
                        r_rr_ptr   <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt < HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: behavioural data memory and a read-data scoreboard around dmem_arbiter.
// Expected read data comes from a reference memory that is updated using the bench's own write stimulus.
module tb_dmem_arbiter;

    localparam int DBITS     = 32;
    localparam int ADDR_BITS = 11;
    localparam int MAX_HOLD  = 4;
    localparam int DEPTH     = 1 << ADDR_BITS;

    logic                 clk;
    logic                 reset;
    logic                 m0_req, m1_req, m0_we, m1_we;
    logic [ADDR_BITS-1:0] m0_addr, m1_addr;
    logic [DBITS-1:0]     m0_wdata, m1_wdata;
    logic                 m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DBITS-1:0]     m0_rdata, m1_rdata;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DBITS-1:0]     mem_wdata, mem_rdata;
    logic                 mem_we;

    logic [DBITS-1:0]     mem     [0:DEPTH-1];
    logic [DBITS-1:0]     ref_mem [0:DEPTH-1];
    logic [DBITS-1:0]     q0[$];
    logic [DBITS-1:0]     q1[$];
    logic                 mon_en;
    int                   n_tests;
    int                   n_fail;

    dmem_arbiter #(.DBITS(DBITS), .ADDR_BITS(ADDR_BITS), .MAX_HOLD(MAX_HOLD)) u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_m0_req    (m0_req),
        .i_m0_we     (m0_we),
        .i_m0_addr   (m0_addr),
        .i_m0_wdata  (m0_wdata),
        .i_m1_req    (m1_req),
        .i_m1_we     (m1_we),
        .i_m1_addr   (m1_addr),
        .i_m1_wdata  (m1_wdata),
        .o_m0_gnt    (m0_gnt),
        .o_m1_gnt    (m1_gnt),
        .o_m0_rvalid (m0_rvalid),
        .o_m1_rvalid (m1_rvalid),
        .o_m0_rdata  (m0_rdata),
        .o_m1_rdata  (m1_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DBITS-1:0] init_word(input int a);
        return (a == 5) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | a);
    endfunction

    assign mem_rdata = mem[mem_addr];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cyc();
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        m0_we  = 1'b0;
        m1_we  = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b0;
    endtask

    // Read-return monitor: rvalid timing, scoreboard pops, then record this cycle's accesses.
    initial begin
        logic prev_rd0, prev_rd1, prev_rst;
        logic [DBITS-1:0] e;
        prev_rd0 = 1'b0;
        prev_rd1 = 1'b0;
        prev_rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_val("m0_rvalid_timing", m0_rvalid, prev_rd0 && !prev_rst);
                check_val("m1_rvalid_timing", m1_rvalid, prev_rd1 && !prev_rst);
                if (m0_rvalid) begin
                    check_val("m0_sb_nonempty", q0.size() > 0, 1);
                    if (q0.size() > 0) begin
                        e = q0.pop_front();
                        check_val("m0_rdata_sb", m0_rdata, e);
                    end
                end
                if (m1_rvalid) begin
                    check_val("m1_sb_nonempty", q1.size() > 0, 1);
                    if (q1.size() > 0) begin
                        e = q1.pop_front();
                        check_val("m1_rdata_sb", m1_rdata, e);
                    end
                end
                if (!reset && m0_gnt && !m0_we) q0.push_back(ref_mem[m0_addr]);
                if (!reset && m1_gnt && !m1_we) q1.push_back(ref_mem[m1_addr]);
                if (m0_gnt && m0_we) ref_mem[m0_addr] = m0_wdata;
                if (m1_gnt && m1_we) ref_mem[m1_addr] = m1_wdata;
                prev_rd0 = m0_gnt && !m0_we;
                prev_rd1 = m1_gnt && !m1_we;
                prev_rst = reset;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got;
        int   owner;
        n_tests  = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        m0_req   = 1'b0;
        m1_req   = 1'b0;
        m0_we    = 1'b0;
        m1_we    = 1'b0;
        m0_addr  = '0;
        m1_addr  = '0;
        m0_wdata = '0;
        m1_wdata = '0;

        do_reset();
        mon_en = 1'b1;
        sample();
        check_val("rst_m0_gnt", m0_gnt, 0);
        check_val("rst_m1_gnt", m1_gnt, 0);
        check_val("rst_m0_rvalid", m0_rvalid, 0);
        check_val("rst_m1_rvalid", m1_rvalid, 0);
        check_val("rst_m0_rdata", m0_rdata, 0);
        check_val("rst_m1_rdata", m1_rdata, 0);
        check_val("rst_mem_we", mem_we, 0);

        // m0 single read of address 5
        next_cyc();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd5;
        sample();
        check_val("s1_m0_gnt_c0", m0_gnt, 0);
        next_cyc();
        sample();
        check_val("s1_m0_gnt_c1", m0_gnt, 1);
        check_val("s1_mem_addr_c1", mem_addr, 5);
        next_cyc();
        m0_req = 1'b0;
        sample();
        check_val("s1_m0_rvalid_c2", m0_rvalid, 1);
        check_val("s1_m0_rdata_c2", m0_rdata, 32'hDEAD_BEEF);

        // simultaneous first requests: m0 writes, then m1 reads the same word
        do_reset();
        next_cyc();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'd3; m0_wdata = 32'h11;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd3;
        sample();
        check_val("s2_m0_gnt_c0", m0_gnt, 0);
        check_val("s2_m1_gnt_c0", m1_gnt, 0);
        next_cyc();
        sample();
        check_val("s2_m0_gnt_c1", m0_gnt, 1);
        check_val("s2_m1_gnt_c1", m1_gnt, 0);
        check_val("s2_mem_we_c1", mem_we, 1);
        check_val("s2_mem_addr_c1", mem_addr, 3);
        check_val("s2_mem_wdata_c1", mem_wdata, 32'h11);
        next_cyc();
        m0_req = 1'b0; m0_we = 1'b0;
        sample();
        got = m1_gnt;
        for (int i = 0; i < 5 && !got; i++) begin
            next_cyc();
            sample();
            got = m1_gnt;
        end
        check_val("s2_m1_gnt_seen", got, 1);
        next_cyc();
        m1_req = 1'b0;
        sample();
        check_val("s2_m1_rvalid", m1_rvalid, 1);
        check_val("s2_m1_rdata", m1_rdata, 32'h11);

`ifdef DMEM_ARB_FIXED_PRIO_EN
        // m1 streams reads; m0 preempts one cycle after raising its request
        do_reset();
        next_cyc();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd21;
        sample();
        check_val("fp_m1_gnt_c0", m1_gnt, 0);
        next_cyc();
        sample();
        check_val("fp_m1_gnt_c1", m1_gnt, 1);
        next_cyc();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd20;
        sample();
        check_val("fp_m0_gnt_t", m0_gnt, 0);
        check_val("fp_m1_gnt_t", m1_gnt, 1);
        for (int k = 1; k <= 3; k++) begin
            next_cyc();
            sample();
            check_val($sformatf("fp_m0_gnt_t%0d", k), m0_gnt, 1);
            check_val($sformatf("fp_m1_gnt_t%0d", k), m1_gnt, 0);
            check_val($sformatf("fp_mem_addr_t%0d", k), mem_addr, 20);
        end
        next_cyc();
        m0_req = 1'b0;
        sample();
        check_val("fp_m0_gnt_drop", m0_gnt, 0);
        next_cyc();
        sample();
        check_val("fp_m1_gnt_resume", m1_gnt, 1);
        next_cyc();
        m1_req = 1'b0;
        sample();
`else
        // both stream reads: four grants each, owners back to back
        do_reset();
        next_cyc();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd21;
        for (int c = 0; c < 17; c++) begin
            sample();
            owner = (c == 0) ? -1 : (((c - 1) / MAX_HOLD) % 2);
            check_val($sformatf("hold_m0_gnt_c%0d", c), m0_gnt, owner == 0);
            check_val($sformatf("hold_m1_gnt_c%0d", c), m1_gnt, owner == 1);
            if (owner == 1) check_val($sformatf("hold_mem_addr_c%0d", c), mem_addr, 21);
            if (c < 16) next_cyc();
        end
        next_cyc();
        m0_req = 1'b0;
        m1_req = 1'b0;
        sample();
`endif

        // m1 writes then drops its request while m0 is quiet
        do_reset();
        next_cyc();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'd8; m1_wdata = 32'h88;
        sample();
        check_val("s4_m1_gnt_c0", m1_gnt, 0);
        next_cyc();
        sample();
        check_val("s4_m1_gnt_c1", m1_gnt, 1);
        check_val("s4_mem_we_c1", mem_we, 1);
        check_val("s4_mem_addr_c1", mem_addr, 8);
        check_val("s4_mem_wdata_c1", mem_wdata, 32'h88);
        next_cyc();
        m1_req = 1'b0; m1_we = 1'b0;
        sample();
        check_val("s4_m1_gnt_c2", m1_gnt, 0);
        next_cyc();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd8;
        sample();
        check_val("s4_idle_m0_gnt", m0_gnt, 0);
        check_val("s4_idle_m1_gnt", m1_gnt, 0);
        check_val("s4_idle_mem_we", mem_we, 0);
        check_val("s4_idle_mem_addr", mem_addr, 8);
        next_cyc();
        sample();
        check_val("s4_m0_gnt", m0_gnt, 1);
        next_cyc();
        m0_req = 1'b0;
        sample();
        check_val("s4_m0_rvalid", m0_rvalid, 1);
        check_val("s4_m0_rdata", m0_rdata, 32'h88);

        // reset lands in the cycle m1 is granted a read
        do_reset();
        next_cyc();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd9;
        sample();
        check_val("s5_m1_gnt_c0", m1_gnt, 0);
        next_cyc();
        reset = 1'b1;
        sample();
        check_val("s5_m1_gnt_c1", m1_gnt, 1);
        next_cyc();
        reset  = 1'b0;
        m1_req = 1'b0;
        sample();
        check_val("s5_m1_rvalid", m1_rvalid, 0);
        check_val("s5_m0_rvalid", m0_rvalid, 0);
        check_val("s5_m0_gnt", m0_gnt, 0);
        check_val("s5_m1_gnt", m1_gnt, 0);
        check_val("s5_m0_rdata", m0_rdata, 0);
        check_val("s5_m1_rdata", m1_rdata, 0);
        check_val("s5_mem_we", mem_we, 0);

        next_cyc();
        next_cyc();
        sample();
        check_val("q0_drained", q0.size(), 0);
        check_val("q1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
